inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Reverse of the instruction decoder: accepts decoded fields (opcode, func, register fields, imm) over a
//  valid/ready handshake, packs them into 32-bit instruction words, buffers them in a small FIFO and writes
//  them sequentially into instruction memory. Serves as the program loader between the host/test front end
//  and IMEM; the decoder then reads the words back unchanged.
// PARAMETERS
//  ADDR_W     10  IMEM word-address width; capacity 2**ADDR_W words
//  FIFO_DEPTH 4   encoded-word buffer depth; must be a power of 2, >= 2
//  BASE_ADDR  0   first IMEM word address written after start
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  reset       in   1       synchronous, active-high
//  start       in   1       1-cycle pulse; begins a load; honoured only in IDLE or DONE
//  in_valid    in   1       field tuple valid
//  in_ready    out  1       tuple accepted when in_valid & in_ready
//  in_opcode   in   4       opcode field, bits [3:0]
//  in_func     in   4       func field, bits [7:4]
//  in_fa       in   4       register field A, bits [31:28]
//  in_fb       in   4       register field B, bits [27:24]
//  in_fc       in   4       register field C, bits [23:20]; R-format only
//  in_imm      in   16      immediate, bits [23:8]; I-format only
//  in_last     in   1       marks the final tuple of the program
//  mem_we      out  1       IMEM write strobe; write occurs when mem_we & mem_ready
//  mem_ready   in   1       IMEM can accept a write this cycle
//  mem_addr    out  ADDR_W  IMEM word address
//  mem_wdata   out  32      encoded instruction word
//  done        out  1       high in DONE until next start or reset
//  word_count  out  ADDR_W+1 words written to IMEM in this load
//  err_illegal out  1       sticky: an illegal opcode was received
//  err_count   out  8       illegal tuples dropped; saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; FIFO emptied; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0,
//   word_count=0, err_illegal=0, err_count=0. Reset mid-load discards all buffered words, no further writes.
//  Encoding: R-format (opcode 0 ALUR, 2 CMPR): {fa,fb,fc,12'h000,func,opcode}.
//   I-format (8 ALUI, 9 LW, 5 SW, 10 CMPI, 6 BRANCH, 11 JAL): {fa,fb,imm,func,opcode}.
//   Any other opcode is illegal: handshake completes, word not enqueued, err_illegal<=1, err_count+1 (sat).
//  FSM: IDLE -start-> LOAD (clears word_count, err_*, done; mem_addr<=BASE_ADDR).
//   LOAD: in_ready = !fifo_full & (enqueued_total < 2**ADDR_W). Accepting a tuple with in_last=1 -> DRAIN
//   (in_last on an illegal tuple also -> DRAIN). DRAIN: in_ready=0; when FIFO empty and no write pending
//   -> DONE. DONE: done=1; start -> LOAD as from IDLE. start in LOAD/DRAIN ignored.
//  Latency: tuple accepted at edge t is visible on mem_wdata/mem_we from cycle t+1 (registered FIFO head).
//  Write side: mem_we = !fifo_empty in LOAD/DRAIN; mem_addr/mem_wdata stable while mem_we & !mem_ready.
//   On each write: dequeue, mem_addr+1, word_count+1. Enqueue and dequeue in the same cycle both occur;
//   in_ready derives from the registered full flag only (no same-cycle pass-through when full).
//  Capacity: once 2**ADDR_W words enqueued, in_ready stays 0 until in_last cannot arrive -> host must
//   not exceed capacity; mem_addr never wraps past BASE_ADDR+2**ADDR_W-1 (mod 2**ADDR_W).
// STRUCTURE
//  Shared include isa_defs.vh: opcode constants (ALUR..JAL), field bit positions, R-format predicate,
//   legal-opcode predicate; the decoder uses the same file.
//  Sub-module inst_fifo (DEPTH, WIDTH=32; registered head, full/empty flags). FSM, encoder, counters top.
// TESTING
//  ALUR op=0 func=3 fa=1 fb=2 fc=3 imm=FFFF, last -> one write mem_addr=0, wdata=32'h1230_0030; done.
//  ALUI op=8 func=0 fa=4 fb=5 imm=BEEF -> wdata=32'h45BE_EF08; 1-cycle latency accept->mem_we.
//  Op=4 between two legal tuples -> handshake completes; 2 writes, addrs 0,1; err_illegal=1, err_count=1.
//  mem_ready=0 for 10 cycles with 6 tuples offered -> in_ready drops after 4 buffered; data held; all
//   6 words written in order once mem_ready=1, word_count=6.
//  Reset asserted in DRAIN with 3 words buffered -> next cycle mem_we=0, FIFO empty, all outputs at reset.
//  start during LOAD ignored; start in DONE -> word_count=0, done=0, writes restart at BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_loader_pkg.sv
// ISA definitions shared by the program loader and the decoder: opcodes, format predicates
// and the field packing used to build a 32-bit instruction word.
package inst_encoder_loader_pkg;

  localparam logic [3:0] OpAlur   = 4'd0;
  localparam logic [3:0] OpCmpr   = 4'd2;
  localparam logic [3:0] OpSw     = 4'd5;
  localparam logic [3:0] OpBranch = 4'd6;
  localparam logic [3:0] OpAlui   = 4'd8;
  localparam logic [3:0] OpLw     = 4'd9;
  localparam logic [3:0] OpCmpi   = 4'd10;
  localparam logic [3:0] OpJal    = 4'd11;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} load_state_e;

  function automatic logic is_r_format(input logic [3:0] op);
    return (op == OpAlur) || (op == OpCmpr);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return is_r_format(op) || (op == OpAlui) || (op == OpLw) || (op == OpSw) ||
           (op == OpCmpi) || (op == OpBranch) || (op == OpJal);
  endfunction

  // R-format carries fc in [23:20] and zeros below; I-format carries imm in [23:8].
  function automatic logic [31:0] encode_inst(input logic [3:0]  op,
                                              input logic [3:0]  func,
                                              input logic [3:0]  fa,
                                              input logic [3:0]  fb,
                                              input logic [3:0]  fc,
                                              input logic [15:0] imm);
    if (is_r_format(op)) begin
      return {fa, fb, fc, 12'h000, func, op};
    end
    return {fa, fb, imm, func, op};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO for encoded instruction words; head is read straight from the
// storage registers so a pushed word is visible the cycle after the push.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == (PtrW + 1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: packs decoded instruction fields into 32-bit words, buffers them and
// writes them sequentially into instruction memory starting at BASE_ADDR.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_fa,
  input  logic [3:0]        in_fb,
  input  logic [3:0]        in_fc,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   Capacity = {1'b1, {ADDR_W{1'b0}}};

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [ADDR_W:0]   enq_total_q, enq_total_d;
  logic              err_illegal_q, err_illegal_d;
  logic [7:0]        err_count_q, err_count_d;

  logic        fifo_full, fifo_empty, accept, push, wr;
  logic [31:0] enc_word, fifo_rdata;

  assign enc_word = encode_inst(in_opcode, in_func, in_fa, in_fb, in_fc, in_imm);

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    word_count_d  = word_count_q;
    enq_total_d   = enq_total_q;
    err_illegal_d = err_illegal_q;
    err_count_d   = err_count_q;

    // Capacity guard counts only words actually buffered, so illegal tuples never consume it.
    in_ready = (state_q == StLoad) && !fifo_full && (enq_total_q != Capacity);
    accept   = in_valid && in_ready;
    push     = accept && is_legal_op(in_opcode);
    mem_we   = ((state_q == StLoad) || (state_q == StDrain)) && !fifo_empty;
    wr       = mem_we && mem_ready;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d       = StLoad;
          mem_addr_d    = BaseAddr;
          word_count_d  = '0;
          enq_total_d   = '0;
          err_illegal_d = 1'b0;
          err_count_d   = '0;
        end
      end
      StLoad: begin
        if (accept && in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr) begin
      mem_addr_d   = mem_addr_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
    end
    if (push) begin
      enq_total_d = enq_total_q + 1'b1;
    end
    if (accept && !is_legal_op(in_opcode)) begin
      err_illegal_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_addr_q    <= BaseAddr;
      word_count_q  <= '0;
      enq_total_q   <= '0;
      err_illegal_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      word_count_q  <= word_count_d;
      enq_total_q   <= enq_total_d;
      err_illegal_q <= err_illegal_d;
      err_count_q   <= err_count_d;
    end
  end

  inst_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(enc_word),
    .pop  (wr),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = fifo_rdata;
  assign done        = (state_q == StDone);
  assign word_count  = word_count_q;
  assign err_illegal = err_illegal_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomised and directed bench for inst_encoder_loader; expected IMEM traffic comes from a
// queue-based model that encodes tuples straight from the instruction format rules.
module tb_inst_encoder_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic          mem_ready = 1'b1;
  logic [3:0]    in_opcode = '0, in_func = '0, in_fa = '0, in_fb = '0, in_fc = '0;
  logic [15:0]   in_imm = '0;
  logic          in_ready, mem_we, done, err_illegal;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  inst_encoder_loader #(
    .ADDR_W(AW),
    .FIFO_DEPTH(4),
    .BASE_ADDR(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_func    (in_func),
    .in_fa      (in_fa),
    .in_fb      (in_fb),
    .in_fc      (in_fc),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .word_count (word_count),
    .err_illegal(err_illegal),
    .err_count  (err_count)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          exp_words = 0, exp_written = 0, exp_err = 0;
  bit          exp_ill = 1'b0;
  int          ready_mode = 0;  // 0: always ready, 1: stalled, 2: random
  logic [31:0] last_wdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference encoder taken from the format table; returns 0 for an illegal opcode.
  function automatic bit model_encode(input int op, input logic [3:0] func, input logic [3:0] fa,
                                      input logic [3:0] fb, input logic [3:0] fc,
                                      input logic [15:0] imm, output logic [31:0] w);
    logic [3:0] o;
    o = 4'(op);
    w = '0;
    if (op == 0 || op == 2) begin
      w = {fa, fb, fc, 12'h000, func, o};
      return 1'b1;
    end
    if (op == 8 || op == 9 || op == 5 || op == 10 || op == 6 || op == 11) begin
      w = {fa, fb, imm, func, o};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'b0;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Every IMEM write must match the model queue head at the next sequential address.
  initial forever begin
    logic [31:0] w;
    @(negedge clk);
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wdata", mem_wdata, w);
        check("addr", 32'(mem_addr), 32'(exp_written % (1 << AW)));
      end
      last_wdata = mem_wdata;
      exp_written++;
    end
  end

  task automatic do_start();
    exp_q.delete();
    exp_words = 0;
    exp_written = 0;
    exp_err = 0;
    exp_ill = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int op, input logic [3:0] func, input logic [3:0] fa,
                      input logic [3:0] fb, input logic [3:0] fc, input logic [15:0] imm,
                      input bit last);
    logic [31:0] w;
    bit ok = 1'b0;
    in_valid = 1'b1; in_opcode = 4'(op); in_func = func; in_fa = fa; in_fb = fb;
    in_fc = fc; in_imm = imm; in_last = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        if (model_encode(op, func, fa, fb, fc, imm, w)) begin
          exp_q.push_back(w);
          exp_words++;
        end else begin
          exp_ill = 1'b1;
          if (exp_err < 255) exp_err++;
        end
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (done === 1'b1);
      @(posedge clk); #1;
    end
    check("done_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err", {23'd0, err_illegal, err_count}, 32'd0);
    @(posedge clk); #1;

    // Single R-format word.
    do_start();
    send(0, 4'h3, 4'h1, 4'h2, 4'h3, 16'hFFFF, 1'b1);
    wait_done();
    check("alur_word", last_wdata, 32'h1230_0030);
    check("alur_count", 32'(word_count), 32'd1);

    // I-format word appears one cycle after acceptance.
    do_start();
    send(8, 4'h0, 4'h4, 4'h5, 4'h0, 16'hBEEF, 1'b1);
    @(negedge clk);
    check("alui_latency_we", 32'(mem_we), 32'd1);
    check("alui_wdata", mem_wdata, 32'h45BE_EF08);
    @(posedge clk); #1;
    wait_done();

    // Illegal opcode between two legal ones.
    do_start();
    send(8, 4'h1, 4'h1, 4'h1, 4'h0, 16'h1234, 1'b0);
    send(4, 4'h2, 4'h2, 4'h2, 4'h2, 16'h5678, 1'b0);
    send(2, 4'h3, 4'h3, 4'h3, 4'h3, 16'h9ABC, 1'b1);
    wait_done();
    check("ill_flag", 32'(err_illegal), 32'd1);
    check("ill_count", 32'(err_count), 32'd1);
    check("ill_words", 32'(word_count), 32'd2);

    // Back-pressure: six tuples offered while IMEM is stalled.
    ready_mode = 1;
    do_start();
    fork
      for (int k = 0; k < 6; k++) send(9, 4'(k), 4'(k + 1), 4'(k + 2), 4'h0,
                                       16'($urandom), k == 5);
    join_none
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_buffered", 32'(exp_q.size()), 32'd4);
    check("bp_mem_we", 32'(mem_we), 32'd1);
    check("bp_head_held", mem_wdata, exp_q[0]);
    check("bp_no_write", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    ready_mode = 0;
    wait fork;
    wait_done();
    check("bp_words", 32'(word_count), 32'd6);

    // Reset while draining with three words buffered.
    ready_mode = 1;
    do_start();
    for (int k = 0; k < 3; k++) send(8, 4'h7, 4'(k), 4'h9, 4'h0, 16'hA5A5, k == 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("drst_mem_we", 32'(mem_we), 32'd0);
    check("drst_mem_addr", 32'(mem_addr), 32'd0);
    check("drst_wdata", mem_wdata, 32'd0);
    check("drst_outs", {done, in_ready, err_illegal, err_count, 10'd0, word_count}, 32'd0);
    ready_mode = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drst_quiet", 32'(mem_we), 32'd0);
    end
    @(posedge clk); #1;

    // start in LOAD is ignored; start in DONE restarts at the base address.
    do_start();
    send(0, 4'h5, 4'h6, 4'h7, 4'h8, 16'h0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("ign_start_count", 32'(word_count), 32'd1);
    send(11, 4'h1, 4'hF, 4'hE, 4'h0, 16'hC0DE, 1'b1);
    wait_done();
    check("ign_start_words", 32'(word_count), 32'd2);
    check("ign_start_addr", 32'(mem_addr), 32'd2);
    do_start();
    check("restart_count", 32'(word_count), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_addr", 32'(mem_addr), 32'd0);
    send(10, 4'h2, 4'h3, 4'h4, 4'h0, 16'h7777, 1'b1);
    wait_done();

    // Random programs with random opcodes and random IMEM stalls.
    for (int l = 0; l < 6; l++) begin
      int n;
      n = int'($urandom_range(1, 14));
      do_start();
      ready_mode = 2;
      for (int k = 0; k < n; k++)
        send(int'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 16'($urandom), k == n - 1);
      wait_done();
      check("rnd_words", 32'(word_count), 32'(exp_words));
      check("rnd_written", 32'(exp_written), 32'(exp_words));
      check("rnd_err_count", 32'(err_count), 32'(exp_err));
      check("rnd_err_flag", 32'(err_illegal), 32'(exp_ill));
      check("rnd_addr", 32'(mem_addr), 32'(exp_words));
      ready_mode = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
